// File: rtl/final_soc_game_cpu_cpu_debug_ocimem_ctrl_pkg.sv
// Shared definitions for the OCI debug-memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package final_soc_game_cpu_cpu_debug_ocimem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_J_RD  = 3'd1,
      ST_J_CAP = 3'd2,
      ST_J_WR  = 3'd3,
      ST_C_RD  = 3'd4,
      ST_C_CAP = 3'd5
   } ocimem_state_t;

   typedef enum logic {
      PEND_RD = 1'b0,
      PEND_WR = 1'b1
   } pend_kind_t;

   // jdo field positions
   localparam int unsigned JDO_ADDR_LSB = 17;
   localparam int unsigned JDO_DATA_MSB = 34;
   localparam int unsigned JDO_DATA_LSB = 3;
   localparam int unsigned JDO_RD_BIT   = 35;
   localparam int unsigned JDO_GO_BIT   = 34;

   // control register bit indices
   localparam int unsigned CTRL_READY = 0;
   localparam int unsigned CTRL_ERROR = 1;
   localparam int unsigned CTRL_GO    = 2;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

endpackage

// File: rtl/final_soc_game_cpu_cpu_debug_ocimem_ram.sv
// Single-port synchronous debug RAM with byte-lane write enables.
// Latency: read data appears on q one clk after addr is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk, addr (word address), wdata/be/we (write), q (registered read data).
module final_soc_game_cpu_cpu_debug_ocimem_ram
   import final_soc_game_cpu_cpu_debug_ocimem_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [BE_W-1:0]   be,
   input  logic              we,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      q <= mem[addr];
   end

   // Preload hook: vendor memory-init flows attach INIT_FILE to this array;
   // the behavioural array itself starts with undefined contents.
   if (INIT_FILE != "") begin : g_preload
   end

endmodule

// File: rtl/final_soc_game_cpu_cpu_debug_ocimem_ctrl.sv
// OCI debug-memory controller: JTAG strobes and the CPU Avalon debug slave share one debug RAM.
// Latency: JTAG read strobe -> MonDReg in 3 clk; CPU RAM read 2 clk wait then data; CPU RAM write and ctrl access 0 wait.
// Backpressure: avs_waitrequest holds the CPU while JTAG work is pending/in flight or a RAM read is underway.
// Ports: clk/reset_n; jdo + take_action_ocimem_a/b, take_no_action_ocimem_a (JTAG side);
//        avs_* (CPU debug slave); MonDReg/MonAReg (JTAG data/address); monitor_ready/error/go (ctrl reg).
module final_soc_game_cpu_cpu_debug_ocimem_ctrl
   import final_soc_game_cpu_cpu_debug_ocimem_ctrl_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter     RAM_INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W:0]   avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              monitor_go
);

   ocimem_state_t     state;
   pend_kind_t        pend_kind;
   logic              pend_vld;
   logic              rst_done;     // low through reset and the first clk after it

   logic              ctrl_sel;
   logic              jtag_incoming;
   logic              can_idle;
   logic              cpu_ctrl_rd;
   logic              cpu_ctrl_wr;
   logic              cpu_ram_wr;
   logic              jtag_port;

   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_q;
   logic [3:0]        ram_be;
   logic              ram_we;
   logic [31:0]       ctrl_word;
   logic              unused_jdo;

   assign unused_jdo = ^jdo;

   assign ctrl_sel = avs_address[ADDR_W];

   // A JTAG RAM request arriving this cycle already outranks the CPU, so a
   // coincident CPU access is not started ahead of it.
   assign jtag_incoming = take_action_ocimem_b | take_no_action_ocimem_a
                        | (take_action_ocimem_a & jdo[JDO_RD_BIT]);

   assign can_idle    = rst_done && (state == ST_IDLE) && !pend_vld && !jtag_incoming;
   assign cpu_ctrl_rd = can_idle && avs_read && ctrl_sel;
   assign cpu_ctrl_wr = can_idle && avs_write && !avs_read && ctrl_sel;
   assign cpu_ram_wr  = can_idle && avs_write && !avs_read && !ctrl_sel;

   assign jtag_port = (state == ST_J_RD) || (state == ST_J_WR);
   assign ram_addr  = jtag_port ? MonAReg : avs_address[ADDR_W-1:0];
   assign ram_wdata = (state == ST_J_WR) ? MonDReg : avs_writedata;
   assign ram_be    = (state == ST_J_WR) ? 4'hF : avs_byteenable;
   assign ram_we    = (state == ST_J_WR) || cpu_ram_wr;

   always_comb begin
      ctrl_word             = '0;
      ctrl_word[CTRL_READY] = monitor_ready;
      ctrl_word[CTRL_ERROR] = monitor_error;
      ctrl_word[CTRL_GO]    = monitor_go;
   end

   assign avs_readdata    = (state == ST_C_CAP) ? ram_q
                          : cpu_ctrl_rd         ? ctrl_word : '0;
   assign avs_waitrequest = !((state == ST_C_CAP) || cpu_ctrl_rd || cpu_ctrl_wr || cpu_ram_wr);

   final_soc_game_cpu_cpu_debug_ocimem_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (RAM_INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .be    (ram_be),
      .we    (ram_we),
      .q     (ram_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         pend_vld      <= 1'b0;
         pend_kind     <= PEND_RD;
         rst_done      <= 1'b0;
         MonAReg       <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
         monitor_go    <= 1'b0;
      end else begin
         rst_done <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (rst_done) begin
                  if (pend_vld) begin
                     pend_vld <= 1'b0;
                     state    <= (pend_kind == PEND_WR) ? ST_J_WR : ST_J_RD;
                  end else if (can_idle && avs_read && !ctrl_sel) begin
                     state <= ST_C_RD;
                  end else if (cpu_ctrl_wr) begin
                     monitor_ready <= avs_writedata[CTRL_READY];
                     monitor_error <= avs_writedata[CTRL_ERROR];
                     monitor_go    <= avs_writedata[CTRL_GO];
                  end
               end
            end
            ST_J_RD:  state <= ST_J_CAP;
            ST_J_CAP: begin
               MonDReg <= ram_q;
               state   <= ST_IDLE;
            end
            ST_J_WR: begin
               MonAReg <= MonAReg + ADDR_W'(1);
               state   <= ST_IDLE;
            end
            ST_C_RD:  state <= ST_C_CAP;
            ST_C_CAP: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase

         // Strobe handling comes last so a new JTAG command overrides any
         // same-edge FSM update of MonAReg/MonDReg and refills the slot.
         if (take_action_ocimem_b) begin
            MonDReg   <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            pend_vld  <= 1'b1;
            pend_kind <= PEND_WR;
         end else if (take_action_ocimem_a) begin
            MonAReg <= jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_GO_BIT]) begin
               monitor_go    <= 1'b1;
               monitor_ready <= 1'b0;
            end
            if (jdo[JDO_RD_BIT]) begin
               pend_vld  <= 1'b1;
               pend_kind <= PEND_RD;
            end
         end else if (take_no_action_ocimem_a) begin
            MonAReg   <= MonAReg + ADDR_W'(1);
            pend_vld  <= 1'b1;
            pend_kind <= PEND_RD;
         end
      end
   end

endmodule
